pcie_msi_tlp_gen: RTL and testbench



---
 rtl/pcie_msi_pkg.sv | 39 +++
 rtl/pcie_msi_tlp_hdr.sv | 39 +++
 rtl/pcie_msi_tlp_gen.sv | 208 ++++++++++++++++++++
 tb/tb_pcie_msi_tlp_gen.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_msi_pkg.sv
// Shared types and helpers for the MSI Memory Write TLP generator.
// Used by pcie_msi_tlp_gen and pcie_msi_tlp_hdr.
package pcie_msi_pkg;

    localparam logic [2:0] FMT_3DW_D = 3'b010;
    localparam logic [2:0] FMT_4DW_D = 3'b011;
    localparam logic [4:0] TYPE_MEM  = 5'b00000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_HDR2,
        ST_HDR3,
        ST_DATA
    } msi_state_e;

    typedef struct packed {
        logic [63:0] addr;
        logic [15:0] data;
        logic [4:0]  vec;
        logic [2:0]  mme;
        logic [15:0] rid;
    } msi_req_t;

    localparam int MSI_REQ_W = $bits(msi_req_t);

    // Replace the low n bits of the message data with the vector, n = min(mme, 5).
    function automatic logic [15:0] msi_fold_vec(input logic [15:0] data,
                                                 input logic [4:0]  vec,
                                                 input logic [2:0]  mme);
        logic [2:0]  n;
        logic [15:0] mask;
        n    = (mme > 3'd5) ? 3'd5 : mme;
        mask = (16'h0001 << n) - 16'h0001;
        return (data & ~mask) | ({11'd0, vec} & mask);
    endfunction

endpackage

// File: rtl/pcie_msi_tlp_hdr.sv
// Combinational builder of the MWr header DWs, payload DW and 3DW/4DW flag
// for one latched MSI request.
module pcie_msi_tlp_hdr
    import pcie_msi_pkg::*;
#(
    parameter logic [2:0] TC   = 3'b000,
    parameter logic [1:0] ATTR = 2'b00
)(
    input  logic [MSI_REQ_W-1:0] i_req,
    input  logic [7:0]           i_tag,
    output logic [31:0]          o_dw0,
    output logic [31:0]          o_dw1,
    output logic [31:0]          o_dw2,
    output logic [31:0]          o_dw3,
    output logic [31:0]          o_dwd,
    output logic                 o_is4dw
);

    msi_req_t    w_req;
    logic        w_is4dw;
    logic [31:0] w_addr_lo;
    logic        w_unused_addr;

    assign w_req         = i_req;
    assign w_is4dw       = (w_req.addr[63:32] != 32'd0);
    assign w_addr_lo     = {w_req.addr[31:2], 2'b00};
    assign w_unused_addr = ^w_req.addr[1:0];

    // {fmt, type, R, TC, R, TD, EP, ATTR, AT, length}
    assign o_dw0 = {(w_is4dw ? FMT_4DW_D : FMT_3DW_D), TYPE_MEM, 1'b0, TC, 4'b0000,
                    1'b0, 1'b0, ATTR, 2'b00, 10'd1};
    assign o_dw1 = {w_req.rid, i_tag, 4'h0, 4'hF};
    assign o_dw2 = w_is4dw ? w_req.addr[63:32] : w_addr_lo;
    assign o_dw3 = w_addr_lo;
    assign o_dwd = {16'h0000, msi_fold_vec(w_req.data, w_req.vec, w_req.mme)};

    assign o_is4dw = w_is4dw;

endmodule

// File: rtl/pcie_msi_tlp_gen.sv
// Serialises MSI requests into posted MWr TLPs on a 32-bit TX stream.
// Optional one-entry request queue: define PCIE_MSI_TLP_QUEUE_EN.
module pcie_msi_tlp_gen
    import pcie_msi_pkg::*;
#(
    parameter logic [2:0] TC       = 3'b000,
    parameter logic [1:0] ATTR     = 2'b00,
    parameter logic [7:0] TAG_INIT = 8'h00
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        msi_req_valid,
    output logic        msi_req_ready,
    input  logic [63:0] msi_addr,
    input  logic [15:0] msi_data,
    input  logic [4:0]  msi_vec,
    input  logic [2:0]  msi_mme,
    input  logic [15:0] requester_id,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] tx_data,
    output logic        tx_sop,
    output logic        tx_eop,
    output logic        busy
);

    msi_state_e  r_state;
    msi_req_t    r_req;
    logic [7:0]  r_tag;
    logic        r_ready;
    logic        r_tx_valid;
    logic [31:0] r_tx_data;
    logic        r_sop;
    logic        r_eop;
    logic        r_busy;

    msi_req_t    w_in_req;
    msi_req_t    w_src_req;
    logic [7:0]  w_src_tag;
    logic        w_acc;
    logic        w_beat;
    logic        w_last;
    logic        w_launch;
    logic [31:0] w_dw0;
    logic [31:0] w_dw1;
    logic [31:0] w_dw2;
    logic [31:0] w_dw3;
    logic [31:0] w_dwd;
    logic        w_is4dw;

    assign w_in_req = {msi_addr, msi_data, msi_vec, msi_mme, requester_id};
    assign w_acc    = msi_req_valid & r_ready;
    assign w_beat   = r_tx_valid & tx_ready;
    assign w_last   = (r_state == ST_DATA) & w_beat;

`ifdef PCIE_MSI_TLP_QUEUE_EN
    msi_req_t r_q;
    logic     r_q_vld;
    logic     w_q_load;
    logic     w_q_pop;
    logic     w_q_next;

    // Requests taken while a TLP is in flight park in the queue; a parked
    // request launches straight out of DATA, or from IDLE on the next cycle.
    assign w_q_pop  = r_q_vld & ((r_state == ST_IDLE) | w_last);
    assign w_q_load = w_acc & (r_state != ST_IDLE);
    assign w_q_next = w_q_load | (r_q_vld & ~w_q_pop);
    assign w_launch = w_q_pop | (w_acc & (r_state == ST_IDLE));

    always_comb begin
        w_src_req = r_req;
        w_src_tag = r_tag;
        if (r_state == ST_IDLE) begin
            w_src_req = r_q_vld ? r_q : w_in_req;
        end else if (r_state == ST_DATA) begin
            w_src_req = r_q;
            w_src_tag = r_tag + 8'd1;
        end
    end
`else
    assign w_launch  = w_acc & (r_state == ST_IDLE);
    assign w_src_req = (r_state == ST_IDLE) ? w_in_req : r_req;
    assign w_src_tag = r_tag;
`endif

    pcie_msi_tlp_hdr #(
        .TC   (TC),
        .ATTR (ATTR)
    ) u_hdr (
        .i_req   (w_src_req),
        .i_tag   (w_src_tag),
        .o_dw0   (w_dw0),
        .o_dw1   (w_dw1),
        .o_dw2   (w_dw2),
        .o_dw3   (w_dw3),
        .o_dwd   (w_dwd),
        .o_is4dw (w_is4dw)
    );

    // Request payload registers carry no reset; they are only read after a launch.
    always_ff @(posedge clk) begin
        if (w_launch) begin
            r_req <= w_src_req;
        end
`ifdef PCIE_MSI_TLP_QUEUE_EN
        if (w_q_load) begin
            r_q <= w_in_req;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_tag      <= TAG_INIT;
            r_ready    <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 32'd0;
            r_sop      <= 1'b0;
            r_eop      <= 1'b0;
            r_busy     <= 1'b0;
`ifdef PCIE_MSI_TLP_QUEUE_EN
            r_q_vld    <= 1'b0;
`endif
        end else begin
`ifdef PCIE_MSI_TLP_QUEUE_EN
            r_q_vld <= w_q_next;
            r_ready <= ~w_q_next;
`else
            r_ready <= (r_state == ST_IDLE) ? ~w_acc : w_last;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_state    <= ST_HDR0;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= w_dw0;
                        r_sop      <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                ST_HDR0: begin
                    if (w_beat) begin
                        r_state   <= ST_HDR1;
                        r_tx_data <= w_dw1;
                        r_sop     <= 1'b0;
                    end
                end
                ST_HDR1: begin
                    if (w_beat) begin
                        r_state   <= ST_HDR2;
                        r_tx_data <= w_dw2;
                    end
                end
                ST_HDR2: begin
                    if (w_beat) begin
                        if (w_is4dw) begin
                            r_state   <= ST_HDR3;
                            r_tx_data <= w_dw3;
                        end else begin
                            r_state   <= ST_DATA;
                            r_tx_data <= w_dwd;
                            r_eop     <= 1'b1;
                        end
                    end
                end
                ST_HDR3: begin
                    if (w_beat) begin
                        r_state   <= ST_DATA;
                        r_tx_data <= w_dwd;
                        r_eop     <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_beat) begin
                        r_tag <= r_tag + 8'd1;
                        r_eop <= 1'b0;
                        if (w_launch) begin
                            r_state   <= ST_HDR0;
                            r_tx_data <= w_dw0;
                            r_sop     <= 1'b1;
                        end else begin
                            r_state    <= ST_IDLE;
                            r_tx_valid <= 1'b0;
                            r_tx_data  <= 32'd0;
                            r_busy     <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_tx_valid <= 1'b0;
                    r_sop      <= 1'b0;
                    r_eop      <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign msi_req_ready = r_ready;
    assign tx_valid      = r_tx_valid;
    assign tx_data       = r_tx_data;
    assign tx_sop        = r_sop;
    assign tx_eop        = r_eop;
    assign busy          = r_busy;

endmodule

// File: tb/tb_pcie_msi_tlp_gen.sv
// Randomized self-checking bench for pcie_msi_tlp_gen (default build, no request queue).
module tb_pcie_msi_tlp_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        msi_req_valid;
    logic        msi_req_ready;
    logic [63:0] msi_addr;
    logic [15:0] msi_data;
    logic [4:0]  msi_vec;
    logic [2:0]  msi_mme;
    logic [15:0] requester_id;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] tx_data;
    logic        tx_sop;
    logic        tx_eop;
    logic        busy;

    always #5 clk = ~clk;

    pcie_msi_tlp_gen dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .msi_req_valid (msi_req_valid),
        .msi_req_ready (msi_req_ready),
        .msi_addr      (msi_addr),
        .msi_data      (msi_data),
        .msi_vec       (msi_vec),
        .msi_mme       (msi_mme),
        .requester_id  (requester_id),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_data       (tx_data),
        .tx_sop        (tx_sop),
        .tx_eop        (tx_eop),
        .busy          (busy)
    );

    typedef struct {
        logic [31:0] d;
        logic        sop;
        logic        eop;
    } beat_t;

    beat_t       exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  m_tag;
    int          ready_mode;
    bit          use_model;
    bit          acc_now;
    bit          hold_pend;
    bit          gap_pend;
    logic [31:0] hold_d;
    logic        hold_sop;
    logic        hold_eop;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic s, input logic e);
        beat_t b;
        b.d   = d;
        b.sop = s;
        b.eop = e;
        exp_q.push_back(b);
    endtask

    // Reference TLP from the request fields: header words, then folded payload.
    task automatic model_tlp(input logic [63:0] a, input logic [15:0] data, input logic [4:0] vec,
                             input logic [2:0] mme, input logic [15:0] rid, input logic [7:0] tag);
        int          n;
        int          p;
        logic [15:0] msg;
        logic [31:0] hi;
        logic [31:0] lo;
        n   = (mme > 3'd5) ? 5 : int'(mme);
        p   = 1 << n;
        msg = 16'((int'(data) / p) * p + (int'(vec) % p));
        hi  = a[63:32];
        lo  = {a[31:2], 2'b00};
        push((hi != 32'd0) ? 32'h6000_0001 : 32'h4000_0001, 1'b1, 1'b0);
        push({rid, tag, 8'h0F}, 1'b0, 1'b0);
        if (hi != 32'd0) begin
            push(hi, 1'b0, 1'b0);
            push(lo, 1'b0, 1'b0);
        end else begin
            push(lo, 1'b0, 1'b0);
        end
        push({16'h0000, msg}, 1'b0, 1'b1);
    endtask

    // Called at a negedge: evaluate the coming posedge, then check at the next negedge.
    task automatic do_cycle();
        beat_t b;
        bit    acc;
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ~tx_ready;
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
        hold_pend = tx_valid && !tx_ready;
        hold_d    = tx_data;
        hold_sop  = tx_sop;
        hold_eop  = tx_eop;
        if (tx_valid && tx_ready) begin
            chk("beat_avail", 32'(exp_q.size() > 0), 32'd1);
            chk("busy_tlp", 32'(busy), 32'd1);
            if (exp_q.size() > 0) begin
                b = exp_q.pop_front();
                chk("beat_data", tx_data, b.d);
                chk("beat_sop", 32'(tx_sop), 32'(b.sop));
                chk("beat_eop", 32'(tx_eop), 32'(b.eop));
            end
            if (tx_eop) gap_pend = 1'b1;
        end
        acc     = msi_req_valid && msi_req_ready;
        acc_now = acc;
        if (acc) begin
            if (use_model) model_tlp(msi_addr, msi_data, msi_vec, msi_mme, requester_id, m_tag);
            m_tag++;
        end
        @(negedge clk);
        if (acc) begin
            msi_req_valid = 1'b0;
            chk("latency_valid", 32'(tx_valid), 32'd1);
            chk("latency_sop", 32'(tx_sop), 32'd1);
        end
        if (hold_pend) begin
            chk("hold_valid", 32'(tx_valid), 32'd1);
            chk("hold_data", tx_data, hold_d);
            chk("hold_sop", 32'(tx_sop), 32'(hold_sop));
            chk("hold_eop", 32'(tx_eop), 32'(hold_eop));
        end
        if (gap_pend) begin
            chk("idle_gap_busy", 32'(busy), 32'd0);
            chk("idle_gap_valid", 32'(tx_valid), 32'd0);
            chk("idle_gap_ready", 32'(msi_req_ready), 32'd1);
            gap_pend = 1'b0;
        end
    endtask

    task automatic send_req(input logic [63:0] a, input logic [15:0] data, input logic [4:0] vec,
                            input logic [2:0] mme, input logic [15:0] rid);
        bit got;
        msi_addr      = a;
        msi_data      = data;
        msi_vec       = vec;
        msi_mme       = mme;
        requester_id  = rid;
        msi_req_valid = 1'b1;
        got           = 1'b0;
        for (int i = 0; i < 200; i++) begin
            do_cycle();
            if (acc_now) begin
                got = 1'b1;
                break;
            end
        end
        chk("req_accepted", 32'(got), 32'd1);
        msi_req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && !busy) break;
            do_cycle();
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        msi_req_valid = 1'b0;
        msi_addr      = 64'd0;
        msi_data      = 16'd0;
        msi_vec       = 5'd0;
        msi_mme       = 3'd0;
        requester_id  = 16'd0;
        tx_ready      = 1'b0;
        ready_mode    = 0;
        use_model     = 1'b1;
        hold_pend     = 1'b0;
        gap_pend      = 1'b0;
        m_tag         = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(msi_req_ready), 32'd0);
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_data", tx_data, 32'd0);
        chk("rst_sop", 32'(tx_sop), 32'd0);
        chk("rst_eop", 32'(tx_eop), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        do_cycle();
        chk("idle_ready", 32'(msi_req_ready), 32'd1);

        // 3DW, no folding, tag 0
        use_model = 1'b0;
        push(32'h4000_0001, 1'b1, 1'b0);
        push(32'h0100_000F, 1'b0, 1'b0);
        push(32'hFEE0_1004, 1'b0, 1'b0);
        push(32'h0000_4020, 1'b0, 1'b1);
        send_req(64'h0000_0000_FEE0_1004, 16'h4020, 5'd0, 3'd0, 16'h0100);
        drain();

        // 4DW with tx_ready toggling, tag 1
        ready_mode = 1;
        push(32'h6000_0001, 1'b1, 1'b0);
        push(32'h0100_010F, 1'b0, 1'b0);
        push(32'h0000_0001, 1'b0, 1'b0);
        push(32'h2345_6788, 1'b0, 1'b0);
        push(32'h0000_000D, 1'b0, 1'b1);
        send_req(64'h0000_0001_2345_6788, 16'h0000, 5'd13, 3'd4, 16'h0100);
        drain();

        // mme above 5 folds only five bits, tag 2
        ready_mode = 2;
        push(32'h4000_0001, 1'b1, 1'b0);
        push(32'h0100_020F, 1'b0, 1'b0);
        push(32'hFEE0_0000, 1'b0, 1'b0);
        push(32'h0000_FFFF, 1'b0, 1'b1);
        send_req(64'h0000_0000_FEE0_0000, 16'hFFE0, 5'h1F, 3'd7, 16'h0100);
        drain();
        use_model = 1'b1;

        // Random traffic long enough to wrap the tag
        for (int k = 0; k < 260; k++) begin
            logic [63:0] a;
            a[31:0]  = $urandom;
            a[63:32] = ($urandom_range(0, 1) == 1) ? $urandom : 32'd0;
            send_req(a, 16'($urandom), 5'($urandom), 3'($urandom), 16'($urandom));
            repeat ($urandom_range(0, 2)) do_cycle();
        end
        drain();

        // Asynchronous reset while HDR1 is on the bus
        ready_mode = 0;
        send_req(64'h0000_0000_FEE0_2000, 16'h1234, 5'd1, 3'd1, 16'h0200);
        do_cycle();
        chk("pre_rst_valid", 32'(tx_valid), 32'd1);
        chk("pre_rst_sop", 32'(tx_sop), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(tx_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_data", tx_data, 32'd0);
        chk("midrst_ready", 32'(msi_req_ready), 32'd0);
        exp_q.delete();
        hold_pend = 1'b0;
        gap_pend  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_tag = 8'h00;
        do_cycle();
        do_cycle();

        use_model = 1'b0;
        push(32'h4000_0001, 1'b1, 1'b0);
        push(32'h0100_000F, 1'b0, 1'b0);
        push(32'hFEE0_1004, 1'b0, 1'b0);
        push(32'h0000_4020, 1'b0, 1'b1);
        send_req(64'h0000_0000_FEE0_1004, 16'h4020, 5'd0, 3'd0, 16'h0100);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
